switch_bounce_generator: RTL and testbench
==========================================

SWITCH_BOUNCE_GENERATOR -- requirements
Module: switch_bounce_generator

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 16: cycles the final level is held before done.
REQ-002 SHALL have parameter LFSR_SEED, default 8'hA5: nonzero 8-bit LFSR reset value.
REQ-003 SHALL have parameter WIDTH_BITS, default 4: LFSR bits used for segment width.
REQ-004 SHALL have port clk, input, 1: single clock; all logic updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port cmd_valid, input, 1: a command is offered.
REQ-007 SHALL have port cmd_level, input, 1: target settled switch level.
REQ-008 SHALL have port n_bounces, input, 3: number of bounce pairs (0..7), sampled with the command.
REQ-009 SHALL have port cmd_ready, output, 1: high only in IDLE.
REQ-010 SHALL have port q_out, output, 1: emulated raw, bouncing switch contact, meant to feed a debouncer input.
REQ-011 SHALL have port busy, output, 1: high in BOUNCE and SETTLE.
REQ-012 SHALL have port done, output, 1: one-cycle pulse when the sequence completes.

Function
REQ-013 SHALL implement the FSM states IDLE, BOUNCE, SETTLE and DONE.
REQ-014 SHALL accept a command on the edge where cmd_valid and cmd_ready are both high; cmd_valid outside IDLE SHALL be ignored.
REQ-015 SHALL, when an accepted cmd_level equals q_out, go to DONE with no q_out change.
REQ-016 SHALL, when an accepted cmd_level differs from q_out, toggle q_out on the accept edge and load remaining = 2*n_bounces.
REQ-017 SHALL, on that accept edge, go to SETTLE with counter = SETTLE_CYCLES when remaining = 0, else go to BOUNCE.
REQ-018 SHALL, on entering BOUNCE, load segment width = 1 + lfsr[WIDTH_BITS-1:0] (range 1..16 cycles at default).
REQ-019 SHALL hold q_out for exactly the segment width cycles; on expiry it SHALL toggle q_out, decrement remaining, advance the LFSR one step and load a new width.
REQ-020 SHALL go to SETTLE when remaining = 0 at segment expiry, with no further toggle.
REQ-021 SHALL produce 2*n_bounces+1 total q_out toggles per level change, with the final level equal to cmd_level.
REQ-022 SHALL hold q_out constant in SETTLE for SETTLE_CYCLES cycles, then enter DONE.
REQ-023 SHALL assert done for exactly one cycle in DONE, then return to IDLE; cmd_ready SHALL be high again the following cycle.
REQ-024 SHALL use an 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, stepping only on segment starts; the LFSR SHALL never reach zero.
REQ-025 SHALL use segment and settle counters that never wrap; the counter width SHALL hold max(2^WIDTH_BITS, SETTLE_CYCLES).

Reset
REQ-026 SHALL, with reset high at a clk edge, set state=IDLE, q_out=0, busy=0, done=0, cmd_ready=1 (from the next cycle), lfsr=LFSR_SEED, and clear all counters.
REQ-027 SHALL let reset mid-BOUNCE or mid-SETTLE abort the sequence with no done pulse; reset SHALL win over a simultaneous command.

Structure
REQ-028 SHALL place the state enum, the LFSR polynomial taps and the default seed in the shared package switch_pkg.
REQ-029 SHALL put the LFSR in one sub-module lfsr8 (ports: clk, reset, step, seed, value).

Verification
REQ-030 SHALL cover: reset, then cmd_level=1 with n_bounces=0 -> q_out rises on the accept edge, no other toggles, done exactly 17 cycles after the q_out edge.
REQ-031 SHALL cover: q_out=0 with cmd_level=1 and n_bounces=3 -> exactly 7 toggles, each segment 1..16 cycles matching the LFSR model from seed 0xA5, final q_out=1, then 16 stable cycles and done.
REQ-032 SHALL cover: q_out=1 with cmd_level=1 -> q_out unchanged, done one cycle after accept, busy never high.
REQ-033 SHALL cover: cmd_valid held high during BOUNCE with a different level -> command ignored, cmd_ready=0 until after done.
REQ-034 SHALL cover: reset asserted at the 4th toggle of an n_bounces=7 sequence -> next cycle q_out=0 in IDLE with no done, and a rerun reproduces the same widths as the first run.
REQ-035 SHALL cover: q_out driving a switch_debouncer instance, n_bounces=7 rising then falling -> exactly one debounced rising and one falling transition, each after the final toggle.

Source files
------------

// File: rtl/switch_pkg.sv
// ---------------------------------------------------------------------------
// switch_pkg
//
// Shared definitions for the switch bounce generator:
//   - state_e            : sequencer FSM states
//   - LFSR_TAPS          : tap mask for x^8 + x^6 + x^5 + x^4 + 1
//   - LFSR_DEFAULT_SEED  : default (nonzero) LFSR reset value
//   - lfsr_next()        : one Fibonacci step of the 8-bit LFSR
// ---------------------------------------------------------------------------
package switch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BOUNCE = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Bit i set means stage i feeds the XOR. Stages 7,5,4,3 correspond to the
  // x^8, x^6, x^5 and x^4 terms of the polynomial.
  localparam logic [7:0] LFSR_TAPS         = 8'hB8;
  localparam logic [7:0] LFSR_DEFAULT_SEED = 8'hA5;

  // Shift left, new bit enters at bit 0. The polynomial is primitive, so a
  // nonzero state never maps to zero.
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr8.sv
// ---------------------------------------------------------------------------
// lfsr8
//
// 8-bit Fibonacci LFSR (x^8 + x^6 + x^5 + x^4 + 1) that advances one step
// only when 'step' is high.
//
// Ports:
//   clk   in   rising-edge clock
//   reset in   synchronous active-high reset, loads 'seed'
//   step  in   advance one LFSR step on this edge
//   seed  in   reset value; a zero seed is replaced by the package default
//   value out  current LFSR state (never zero)
// ---------------------------------------------------------------------------
module lfsr8
  import switch_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       step,
  input  logic [7:0] seed,
  output logic [7:0] value
);

  logic [7:0] value_q;
  logic [7:0] value_d;
  logic [7:0] seed_safe;

  always_comb begin
    // An all-zero state would lock the register, so never load one.
    seed_safe = (seed == 8'h00) ? LFSR_DEFAULT_SEED : seed;
    value_d   = value_q;
    if (step) begin
      value_d = lfsr_next(value_q);
    end
    if (value_d == 8'h00) begin
      value_d = seed_safe;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= seed_safe;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/switch_bounce_generator.sv
// ---------------------------------------------------------------------------
// switch_bounce_generator
//
// Emulates a mechanical switch contact for exercising debouncers. A command
// asks for a new settled level; if it differs from the present level the
// output toggles 2*n_bounces+1 times, with every intermediate level held for
// a pseudo-random 1..2^WIDTH_BITS cycles, and then holds the final level for
// SETTLE_CYCLES cycles before pulsing done.
//
// Handshake: a command is taken on a rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready is high only in IDLE, so cmd_valid in
// any other state has no effect; n_bounces and cmd_level are sampled only on
// that accepting edge.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset (wins over a command)
//   cmd_valid  in   command offered
//   cmd_level  in   requested settled level
//   n_bounces  in   bounce pairs (0..7)
//   cmd_ready  out  high in IDLE
//   q_out      out  raw bouncing contact
//   busy       out  high in BOUNCE and SETTLE
//   done       out  one-cycle pulse when the sequence completes
//   dbg_state  out  FSM state (switch_pkg::state_e encoding)
//   dbg_lfsr   out  current LFSR state
// ---------------------------------------------------------------------------
module switch_bounce_generator
  import switch_pkg::*;
#(
  parameter int         SETTLE_CYCLES = 16,
  parameter logic [7:0] LFSR_SEED     = LFSR_DEFAULT_SEED,
  parameter int         WIDTH_BITS    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic       cmd_level,
  input  logic [2:0] n_bounces,
  output logic       cmd_ready,
  output logic       q_out,
  output logic       busy,
  output logic       done,
  output logic [1:0] dbg_state,
  output logic [7:0] dbg_lfsr
);

  // The counter is shared by the bounce segments (up to 2^WIDTH_BITS) and the
  // settle phase (SETTLE_CYCLES); size it for the larger so it never wraps.
  localparam int SEG_MAX = 1 << WIDTH_BITS;
  localparam int CNT_MAX = (SEG_MAX > SETTLE_CYCLES) ? SEG_MAX : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_e           state_q;
  state_e           state_d;
  logic             q_out_q;
  logic             q_out_d;
  logic [3:0]       remaining_q;   // toggles still to make inside BOUNCE
  logic [3:0]       remaining_d;
  logic [CNT_W-1:0] cnt_q;         // cycles left in the current segment/settle
  logic [CNT_W-1:0] cnt_d;

  logic             lfsr_step;
  logic [7:0]       lfsr_value;
  logic [CNT_W-1:0] seg_width;

  // -------------------------------------------------------------------------
  // LFSR: stepped exactly when a new bounce segment starts, so the width
  // sequence after reset is fully determined by the seed.
  // -------------------------------------------------------------------------
  lfsr8 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .step  (lfsr_step),
    .seed  (LFSR_SEED),
    .value (lfsr_value)
  );

  // Width of a segment that starts now: 1 .. 2^WIDTH_BITS.
  assign seg_width = CNT_W'(lfsr_value[WIDTH_BITS-1:0]) + CNT_ONE;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      q_out_q     <= 1'b0;
      remaining_q <= 4'd0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      q_out_q     <= q_out_d;
      remaining_q <= remaining_d;
      cnt_q       <= cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    q_out_d     = q_out_q;
    remaining_d = remaining_q;
    cnt_d       = cnt_q;
    lfsr_step   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_level == q_out_q) begin
            // Already at the requested level: complete without touching q_out.
            state_d = ST_DONE;
          end else begin
            // First edge of the sequence happens right on the accept edge.
            q_out_d     = ~q_out_q;
            remaining_d = {n_bounces, 1'b0};
            if (n_bounces == 3'd0) begin
              state_d = ST_SETTLE;
              cnt_d   = SETTLE_LOAD;
            end else begin
              state_d   = ST_BOUNCE;
              cnt_d     = seg_width;
              lfsr_step = 1'b1;
            end
          end
        end
      end

      ST_BOUNCE: begin
        if (cnt_q <= CNT_ONE) begin
          // Segment expired: make the next edge. The edge that uses up the
          // last remaining toggle lands on cmd_level, so settling starts here.
          q_out_d     = ~q_out_q;
          remaining_d = remaining_q - 4'd1;
          if (remaining_q <= 4'd1) begin
            state_d = ST_SETTLE;
            cnt_d   = SETTLE_LOAD;
          end else begin
            cnt_d     = seg_width;
            lfsr_step = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_SETTLE: begin
        if (cnt_q <= CNT_ONE) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs (pure functions of registered state)
  // -------------------------------------------------------------------------
  always_comb begin
    cmd_ready = (state_q == ST_IDLE);
    busy      = (state_q == ST_BOUNCE) || (state_q == ST_SETTLE);
    done      = (state_q == ST_DONE);
    q_out     = q_out_q;
    dbg_state = state_q;
    dbg_lfsr  = lfsr_value;
  end

endmodule

// File: tb/tb_switch_bounce_generator.sv
// ---------------------------------------------------------------------------
// tb_switch_bounce_generator
//
// Directed bench for switch_bounce_generator with default parameters.
// Segment widths come from a hand-computed table of the LFSR sequence
// starting at 0xA5 (width = 1 + low nibble):
//   A5 4A 95 2A 54 A9 53 A7 4E 9D 3B 77 EE DD
//    6 11  6 11  5 10  4  8 15 14 12  8 15 14
// Cycle numbers are counted in clock edges after the accept edge; the
// accept edge itself is 0. With SETTLE_CYCLES=16, done is seen 16 edges
// after the final q_out edge, i.e. in the 17th cycle counting the cycle in
// which q_out changed as the first.
// ---------------------------------------------------------------------------
module tb_switch_bounce_generator;
  import switch_pkg::*;

  localparam int SETTLE  = 16;
  localparam int DB_N    = 20;   // debouncer stability threshold (> max segment)
  localparam int MAX_CYC = 600;

  localparam int W_TAB [14] = '{6, 11, 6, 11, 5, 10, 4, 8, 15, 14, 12, 8, 15, 14};

  // -------------------------------------------------------------------------
  // Clock / reset / DUT
  // -------------------------------------------------------------------------
  logic       clk       = 1'b0;
  logic       reset     = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_level = 1'b0;
  logic [2:0] n_bounces = 3'd0;
  logic       cmd_ready;
  logic       q_out;
  logic       busy;
  logic       done;
  logic [1:0] dbg_state;
  logic [7:0] dbg_lfsr;

  always #5 clk = ~clk;

  switch_bounce_generator dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_level (cmd_level),
    .n_bounces (n_bounces),
    .cmd_ready (cmd_ready),
    .q_out     (q_out),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state),
    .dbg_lfsr  (dbg_lfsr)
  );

  // -------------------------------------------------------------------------
  // Reference debouncer fed by q_out: output follows the input once it has
  // been stable for DB_N consecutive cycles.
  // -------------------------------------------------------------------------
  logic       db_out;
  logic [4:0] db_cnt;
  logic       db_prev     = 1'b0;
  int         db_rise_cnt = 0;
  int         db_fall_cnt = 0;
  time        db_rise_time = 0;
  time        db_fall_time = 0;

  always @(posedge clk) begin
    if (reset) begin
      db_out <= 1'b0;
      db_cnt <= 5'd0;
    end else if (q_out == db_out) begin
      db_cnt <= 5'd0;
    end else if (db_cnt == 5'(DB_N - 1)) begin
      db_out <= q_out;
      db_cnt <= 5'd0;
    end else begin
      db_cnt <= db_cnt + 5'd1;
    end
  end

  always @(negedge clk) begin
    if (db_out !== db_prev) begin
      if (db_out === 1'b1) begin
        db_rise_cnt++;
        db_rise_time = $time;
      end else begin
        db_fall_cnt++;
        db_fall_time = $time;
      end
    end
    db_prev = db_out;
  end

  // -------------------------------------------------------------------------
  // Scoreboard state
  // -------------------------------------------------------------------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  int          tog_q[$];
  int          done_cyc;
  int          done_cnt;
  int          busy_cnt;
  int          ready_bad;
  time         last_tog_time;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Compare observed gaps between q_out edges against exp_q.
  task automatic check_gaps(input string tag);
    for (int i = 1; i < tog_q.size(); i++) begin
      if (exp_q.size() == 0) begin
        check({tag, "_extra_gap"}, 32'(i), 32'(tog_q.size()));
        break;
      end
      check(tag, 32'(tog_q[i] - tog_q[i-1]), exp_q.pop_front());
    end
    check({tag, "_unused"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic load_widths(input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(32'(W_TAB[i]));
  endtask

  // -------------------------------------------------------------------------
  // Driver tasks (entered and left on a falling edge)
  // -------------------------------------------------------------------------
  // Reset with a command offered at the same time: the command must lose.
  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    cmd_valid = 1'b1;
    cmd_level = 1'b1;
    n_bounces = 3'd2;
    @(negedge clk);
    @(negedge clk);
    check("rst_q_out", 32'(q_out), 32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_done",  32'(done),  32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_lfsr",  32'(dbg_lfsr), 32'hA5);
    reset     = 1'b0;
    cmd_valid = 1'b0;
  endtask

  // Offer one command and watch until done (or an abort reset is issued
  // after abort_at toggles). With hold_valid, cmd_valid stays high with the
  // opposite level for the whole sequence.
  task automatic run_cmd(input logic lvl, input logic [2:0] nb, input bit hold_valid,
                         input int abort_at);
    logic prev_q;
    int   cyc;
    bit   fin;
    tog_q.delete();
    done_cyc  = -1;
    done_cnt  = 0;
    busy_cnt  = 0;
    ready_bad = 0;
    prev_q    = q_out;
    cmd_level = lvl;
    n_bounces = nb;
    cmd_valid = 1'b1;
    cyc = 0;
    fin = 1'b0;
    @(negedge clk);
    if (hold_valid) cmd_level = ~lvl;
    else            cmd_valid = 1'b0;
    while (!fin && cyc < MAX_CYC) begin
      if (q_out !== prev_q) begin
        tog_q.push_back(cyc);
        last_tog_time = $time;
      end
      prev_q = q_out;
      if (busy) busy_cnt++;
      if ((busy || done) && cmd_ready) ready_bad++;
      if (done) begin
        done_cnt++;
        done_cyc  = cyc;
        fin       = 1'b1;
        cmd_valid = 1'b0;
      end else if (abort_at > 0 && tog_q.size() == abort_at) begin
        reset = 1'b1;
        fin   = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    check("run_completed", 32'(fin), 32'd1);
    cmd_valid = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  // Directed scenarios
  // -------------------------------------------------------------------------
  int rise_base;
  int fall_base;
  time t_last;

  initial begin
    // Rising edge without bounce, settle only.
    do_reset();
    run_cmd(1'b1, 3'd0, 1'b0, 0);
    check("nb0_toggles", 32'(tog_q.size()), 32'd1);
    check("nb0_first_edge", (tog_q.size() > 0) ? 32'(tog_q[0]) : 32'hFFFF_FFFF, 32'd0);
    check("nb0_done_cyc", 32'(done_cyc), 32'(SETTLE));
    check("nb0_done_cnt", 32'(done_cnt), 32'd1);
    check("nb0_busy_cyc", 32'(busy_cnt), 32'(SETTLE));
    check("nb0_q_final", 32'(q_out), 32'd1);
    check("nb0_ready_after", 32'(cmd_ready), 32'd1);
    check("nb0_done_after", 32'(done), 32'd0);

    // Same level requested again: immediate completion, no busy.
    run_cmd(1'b1, 3'd5, 1'b0, 0);
    check("same_toggles", 32'(tog_q.size()), 32'd0);
    check("same_done_cyc", 32'(done_cyc), 32'd0);
    check("same_busy_cyc", 32'(busy_cnt), 32'd0);
    check("same_q", 32'(q_out), 32'd1);
    check("same_ready_after", 32'(cmd_ready), 32'd1);
    check("same_lfsr", 32'(dbg_lfsr), 32'hA5);

    // Three bounce pairs, with a conflicting command held throughout.
    do_reset();
    load_widths(6);
    run_cmd(1'b1, 3'd3, 1'b1, 0);
    check("nb3_toggles", 32'(tog_q.size()), 32'd7);
    check_gaps("nb3_gap");
    check("nb3_done_cyc", 32'(done_cyc), 32'd65);
    check("nb3_busy_cyc", 32'(busy_cnt), 32'd65);
    check("nb3_ready_low", 32'(ready_bad), 32'd0);
    check("nb3_q_final", 32'(q_out), 32'd1);
    check("nb3_ready_after", 32'(cmd_ready), 32'd1);

    // Abort with reset on the 4th edge of a seven-pair run.
    do_reset();
    load_widths(3);
    run_cmd(1'b1, 3'd7, 1'b0, 4);
    check("abort_toggles", 32'(tog_q.size()), 32'd4);
    check_gaps("abort_gap");
    check("abort_q", 32'(q_out), 32'd0);
    check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
    check("abort_done", 32'(done), 32'd0);
    check("abort_done_cnt", 32'(done_cnt), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_lfsr", 32'(dbg_lfsr), 32'hA5);
    reset = 1'b0;

    // Rerun reproduces the full width sequence.
    load_widths(14);
    run_cmd(1'b1, 3'd7, 1'b0, 0);
    check("rerun_toggles", 32'(tog_q.size()), 32'd15);
    check_gaps("rerun_gap");
    check("rerun_done_cyc", 32'(done_cyc), 32'd155);
    check("rerun_q_final", 32'(q_out), 32'd1);

    // Debouncer sees exactly one clean transition per level change.
    do_reset();
    rise_base = db_rise_cnt;
    fall_base = db_fall_cnt;
    run_cmd(1'b1, 3'd7, 1'b0, 0);
    t_last = last_tog_time;
    check("db_up_toggles", 32'(tog_q.size()), 32'd15);
    repeat (DB_N + 10) @(negedge clk);
    check("db_rise_count", 32'(db_rise_cnt - rise_base), 32'd1);
    check("db_fall_count_a", 32'(db_fall_cnt - fall_base), 32'd0);
    check("db_rise_after_last", 32'(db_rise_time > t_last), 32'd1);

    run_cmd(1'b0, 3'd7, 1'b0, 0);
    t_last = last_tog_time;
    check("db_dn_toggles", 32'(tog_q.size()), 32'd15);
    check("db_dn_q_final", 32'(q_out), 32'd0);
    repeat (DB_N + 10) @(negedge clk);
    check("db_fall_count", 32'(db_fall_cnt - fall_base), 32'd1);
    check("db_rise_count_b", 32'(db_rise_cnt - rise_base), 32'd1);
    check("db_fall_after_last", 32'(db_fall_time > t_last), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
